// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts synchronized rising edges of sig_in over
// GATE_CYCLES clk cycles. Define FREQ_METER_OVF_EN for a saturating count and ovf flag.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf
);

  localparam int unsigned    GW   = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]  LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             edge_det;
  logic             win_end;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] cnt_fin;

  // s1/s2 form the synchronizer; s3 only delays s2 for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 & ~s3;
  assign win_end  = (state == MEASURE) && (gate_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = MEASURE;
      MEASURE: if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FREQ_METER_OVF_EN
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic sat;
  logic ovf_fin;

  assign cnt_fin = (edge_det && (edge_cnt != CMAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign ovf_fin = sat | (edge_det & (edge_cnt == CMAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  sat <= 1'b0;
    else if (state == MEASURE && en && !win_end) sat <= ovf_fin;
    else                                         sat <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (win_end) ovf <= ovf_fin;
  end
`else
  assign cnt_fin = edge_cnt + CNT_W'(edge_det);
  assign ovf     = 1'b0;
`endif

  // Clearing on an en drop here matches the zeros IDLE would hold anyway
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (state == MEASURE && en && !win_end) begin
      gate_cnt <= gate_cnt + GW'(1);
      edge_cnt <= cnt_fin;
    end else begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= win_end;
      if (win_end) freq <= cnt_fin;
    end
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated-window frequency meter: counts rising edges of an asynchronous input over a fixed window of system-clock cycles and publishes the count once per window. It is the measuring counterpart to the free-running clock divider. The divider produces divided clocks from `clk`; this block reads a clock or tick back and reports its rate in edges per window. It sits beside the divider in the top level, and its result feeds the display/marquee logic or a self-check of divider taps.

## Interface
- `GATE_CYCLES`, default 100_000_000: window length in `clk` cycles (1 s at 100 MHz); legal range ≥ 2.
- `CNT_W`, default 32: width of the edge counter and the `freq` output.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  synchronous run enable; 1 = measure continuously.
- `sig_in`  in  1  signal under measurement, asynchronous to `clk`.
- `freq`  out  CNT_W  rising-edge count of the last completed window.
- `valid`  out  1  one-cycle pulse when `freq` is updated.
- `ovf`  out  1  last completed window saturated (macro-dependent, see Configuration).

## Operation
- Input path:
  - 2-FF synchronizer on `sig_in`, giving `s1` then `s2`.
  - A third register `s3` holds the previous `s2`.
  - `edge = s2 & ~s3`.
- States: IDLE, MEASURE.
- IDLE:
  - `gate_cnt = 0`, `edge_cnt = 0`.
  - `en = 1` moves to MEASURE on the next cycle.
- MEASURE, non-final cycle:
  - `gate_cnt` increments every cycle.
  - `edge_cnt` increments on each cycle with `edge = 1`.
- MEASURE, final cycle (`gate_cnt == GATE_CYCLES-1`):
  - `freq <= edge_cnt + edge`, with saturation per Configuration.
  - `valid <= 1`.
  - `gate_cnt <= 0`, `edge_cnt <= 0`.
  - Stay in MEASURE if `en = 1`, else go to IDLE.
- Windows are back-to-back; no clock cycle is excluded from measurement.
- `en` deasserted mid-window:
  - Go to IDLE next cycle and discard the partial count.
  - No `valid` pulse; `freq` and `ovf` keep their previous values.
- `en` deasserted in the final cycle: that window still completes and publishes.
- Width rule: counts are unsigned CNT_W bits; `gate_cnt` width is `$clog2(GATE_CYCLES)`.
- Reset (`rst_n = 0`, at any time):
  - State goes to IDLE.
  - `freq = 0`, `valid = 0`, `ovf = 0`.
  - Synchronizer and all counters go to 0.
  - An in-progress window is lost.

## Timing
- Latency from a `sig_in` rise to `edge`: 2–3 `clk` cycles (synchronizer plus edge register).
- Edges within the last ~2 cycles of a window may fall into the next window.
- `sig_in` high and low times must each be ≥ 2 `clk` periods. Maximum measurable rate is `clk/4`; faster inputs are undercounted, with no error flag.
- `valid` rises one cycle after the final window cycle and lasts exactly 1 cycle.
- With `en` held high, `valid` repeats every `GATE_CYCLES` cycles.
- First `valid` after `en` rises from IDLE: `GATE_CYCLES + 1` cycles later.
- `freq` changes only in the same cycle as `valid`.

## Configuration
- Macro: `FREQ_METER_OVF_EN`.
- Defined:
  - `edge_cnt` saturates at 2^CNT_W−1.
  - `ovf` is registered with each published window: 1 if that window saturated, else 0.
- Undefined:
  - `edge_cnt` wraps modulo 2^CNT_W.
  - `ovf` is tied to 0; no saturation logic is built.

## Test plan
- Basic count (GATE_CYCLES=100, `en=1`, `sig_in` period 10 clk at 50% duty) -> every `valid` after the first shows `freq = 10`; `valid` pulses are 100 cycles apart.
- Idle input (`sig_in` held 1, then held 0, for 3 windows) -> `freq = 0` from the second window on; exactly one `valid` per window.
- Enable abort (`en` dropped at cycle 50 of a window with the previous `freq = 10`) -> no `valid` pulse, `freq` stays 10, state is IDLE. Re-enable -> first `valid` 101 cycles later.
- Overflow with macro (CNT_W=4, GATE_CYCLES=100, period 4 clk, i.e. 25 edges):
  - Defined -> `freq = 15`, `ovf = 1`.
  - Undefined -> `freq = 9` (25 mod 16), `ovf = 0`.
- Reset mid-window (`rst_n` low for 3 cycles at cycle 40) -> `freq = 0`, `valid = 0`, `ovf = 0` immediately, without waiting for a clock edge. After release with `en=1`, the next `valid` arrives 101 cycles later with the correct count.
